// File: rtl/mvm_host_ctrl.sv
// Purpose: host-side initiator for one mvm core; buffers operand loads, replays them gaplessly, captures and returns results.
// Latency: load pulse 1 cycle after last wr word, then N*N/N burst cycles; mvm_start 1 cycle after accept; first res_valid N+1 cycles after mvm_done.
// Backpressure: cmd_ready only in IDLE, wr_ready only in FILL; res_ready low holds DRAIN (and all new commands) indefinitely.
// Ports: clk/reset (sync, active-high, shared with the core); cmd_valid/cmd_ready/cmd_op command stream;
//   wr_valid/wr_ready/wr_data operand words (matrix row-major); res_valid/res_ready/res_data/res_last result stream;
//   op_err illegal-op pulse, busy; mvm_loadMatrix/mvm_loadVector/mvm_start/mvm_data_in drive the core, mvm_done/mvm_data_out return.
module mvm_host_ctrl #(
  parameter int MAT_SCALE    = 8,
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = 2*INPUT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [INPUT_WIDTH-1:0]  wr_data,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [OUTPUT_WIDTH-1:0] res_data,
  output logic                    res_last,
  output logic                    op_err,
  output logic                    busy,
  output logic                    mvm_loadMatrix,
  output logic                    mvm_loadVector,
  output logic                    mvm_start,
  output logic [INPUT_WIDTH-1:0]  mvm_data_in,
  input  logic                    mvm_done,
  input  logic [OUTPUT_WIDTH-1:0] mvm_data_out
);

  localparam int N  = MAT_SCALE;
  localparam int NW = N*N;
  localparam int CW = $clog2(NW+1);
  localparam int AW = $clog2(NW);
  localparam int RW = $clog2(N);
  localparam logic [CW-1:0] MAT_WORDS = CW'(NW);
  localparam logic [CW-1:0] VEC_WORDS = CW'(N);
  localparam logic [CW-1:0] LAST_RES  = CW'(N-1);
  localparam logic [AW-1:0] FIRST_ADR = '0;

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_PULSE, S_BURST, S_START, S_WAIT, S_CAPTURE, S_DRAIN
  } state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           count, count_n;
  logic [1:0]              op_q, op_q_n;
  logic                    err_n;
  logic [CW-1:0]           target, last_word, count_inc;
  logic [INPUT_WIDTH-1:0]  op_buf  [NW];
  logic [OUTPUT_WIDTH-1:0] res_buf [N];

  assign target    = (op_q == 2'd0) ? MAT_WORDS : VEC_WORDS;
  assign last_word = target - CW'(1);
  assign count_inc = count + CW'(1);

  always_comb begin
    state_n        = state;
    count_n        = count;
    op_q_n         = op_q;
    err_n          = 1'b0;
    cmd_ready      = 1'b0;
    wr_ready       = 1'b0;
    res_valid      = 1'b0;
    res_last       = 1'b0;
    res_data       = '0;
    mvm_loadMatrix = 1'b0;
    mvm_loadVector = 1'b0;
    mvm_start      = 1'b0;
    busy           = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (cmd_op)
            2'd0, 2'd1: begin
              op_q_n  = cmd_op;
              count_n = '0;
              state_n = S_FILL;
            end
            2'd2:    state_n = S_START;
            default: err_n   = 1'b1;
          endcase
        end
      end
      S_FILL: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          count_n = count_inc;
          if (count == last_word) state_n = S_PULSE;
        end
      end
      S_PULSE: begin
        mvm_loadMatrix = (op_q == 2'd0);
        mvm_loadVector = (op_q != 2'd0);
        count_n        = '0;
        state_n        = S_BURST;
      end
      S_BURST: begin
        count_n = count_inc;
        if (count == last_word) state_n = S_IDLE;
      end
      S_START: begin
        mvm_start = 1'b1;
        state_n   = S_WAIT;
      end
      S_WAIT: begin
        if (mvm_done) begin
          count_n = '0;
          state_n = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        count_n = count_inc;
        if (count == LAST_RES) begin
          count_n = '0;
          state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        res_valid = 1'b1;
        res_data  = res_buf[count[RW-1:0]];
        res_last  = (count == LAST_RES);
        if (res_ready) begin
          count_n = count_inc;
          if (count == LAST_RES) state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // The core operand bus is registered: the word for the next burst cycle is
  // fetched one cycle early, so word k lands k+1 cycles after the load pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      count       <= '0;
      op_q        <= 2'd0;
      op_err      <= 1'b0;
      mvm_data_in <= '0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      op_q   <= op_q_n;
      op_err <= err_n;
      if (state == S_PULSE)
        mvm_data_in <= op_buf[FIRST_ADR];
      else if (state == S_BURST && count != last_word)
        mvm_data_in <= op_buf[count_inc[AW-1:0]];
      else
        mvm_data_in <= '0;
    end
  end

  // Buffers carry no reset; their contents are only read in states that a
  // completed fill or capture leads into.
  always_ff @(posedge clk) begin
    if (!reset && state == S_FILL && wr_valid)
      op_buf[count[AW-1:0]] <= wr_data;
    if (!reset && state == S_CAPTURE)
      res_buf[count[RW-1:0]] <= mvm_data_out;
  end

endmodule

// File: tb/tb_mvm_host_ctrl.sv
// Purpose: self-checking bench for mvm_host_ctrl with a behavioural stand-in for the mvm core.
// Latency: checks load pulse, burst, start and result timing against the documented cycle counts.
// Backpressure: exercises wr_valid gaps and res_ready stalls.
module tb_mvm_host_ctrl;
  localparam int N  = 8;
  localparam int IW = 16;
  localparam int OW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [IW-1:0] wr_data = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [OW-1:0] res_data;
  logic          res_last;
  logic          op_err;
  logic          busy;
  logic          mvm_loadMatrix;
  logic          mvm_loadVector;
  logic          mvm_start;
  logic [IW-1:0] mvm_data_in;
  logic          mvm_done = 1'b0;
  logic [OW-1:0] mvm_data_out = '0;

  always #5 clk = ~clk;

  mvm_host_ctrl #(.MAT_SCALE(N), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .op_err(op_err), .busy(busy),
    .mvm_loadMatrix(mvm_loadMatrix), .mvm_loadVector(mvm_loadVector), .mvm_start(mvm_start),
    .mvm_data_in(mvm_data_in), .mvm_done(mvm_done), .mvm_data_out(mvm_data_out)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Model state: what the host sent, what the core should see, what must come back.
  int ref_mat[N*N];
  int ref_vec[N];
  int core_mat[N*N];
  int core_vec[N];
  int exp_burst[$];
  int exp_kind[$];
  int exp_res[$];
  int seen_res[$];
  int burst_left = 0;
  int burst_idx = 0;
  int burst_kind = 0;
  int starts_exp = 0;
  bit err_pending = 1'b0;
  bit mon_en = 1'b0;

  // Compare process: core-side traffic, op_err timing and result handshakes.
  initial begin
    int w, k, e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (burst_left > 0) begin
          w = 32'h7fff_ffff;
          if (exp_burst.size() > 0) w = exp_burst.pop_front();
          chk("burst_word", longint'($signed(mvm_data_in)), w);
          if (burst_kind == 0) core_mat[burst_idx] = int'($signed(mvm_data_in));
          else core_vec[burst_idx] = int'($signed(mvm_data_in));
          burst_idx++;
          burst_left--;
        end else begin
          chk("din_idle", mvm_data_in, 0);
        end
        if (mvm_loadMatrix || mvm_loadVector) begin
          k = -1;
          if (exp_kind.size() > 0) k = exp_kind.pop_front();
          chk("pulse_kind", mvm_loadMatrix ? 0 : 1, k);
          chk("pulse_onehot", mvm_loadMatrix & mvm_loadVector, 0);
          burst_kind = mvm_loadMatrix ? 0 : 1;
          burst_left = mvm_loadMatrix ? N*N : N;
          burst_idx  = 0;
        end
        if (mvm_start) begin
          chk("start_expected", starts_exp > 0, 1);
          if (starts_exp > 0) starts_exp--;
        end
        chk("op_err", op_err, err_pending);
        err_pending = cmd_valid && cmd_ready && (cmd_op == 2'd3);
        if (res_valid) begin
          chk("res_vld_expected", exp_res.size() > 0, 1);
          if (res_ready && exp_res.size() > 0) begin
            e = exp_res.pop_front();
            chk("res_data", longint'($signed(res_data)), e);
            chk("res_last", res_last, exp_res.size() == 0);
            seen_res.push_back(int'($signed(res_data)));
          end
        end
        if (reset) begin
          burst_left = 0;
          exp_burst.delete();
          exp_kind.delete();
          exp_res.delete();
          starts_exp  = 0;
          err_pending = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op);
    int n = 0;
    step();
    cmd_valid = 1'b1;
    cmd_op    = op;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 500) begin chk("cmd_accept_timeout", 0, 1); break; end
    end
    step();
    cmd_valid = 1'b0;
  endtask

  // abort_at >= 0 asserts reset while burst word abort_at is on the core bus.
  task automatic load(input bit is_mat, input bit gappy, input int abort_at);
    int t = is_mat ? N*N : N;
    int n;
    for (int i = 0; i < t; i++) exp_burst.push_back(is_mat ? ref_mat[i] : ref_vec[i]);
    exp_kind.push_back(is_mat ? 0 : 1);
    send_cmd(is_mat ? 2'd0 : 2'd1);
    for (int i = 0; i < t; i++) begin
      if (gappy && $urandom_range(0, 1) == 1) begin
        wr_valid = 1'b0;
        step();
      end
      wr_valid = 1'b1;
      wr_data  = IW'(is_mat ? ref_mat[i] : ref_vec[i]);
      n = 0;
      forever begin
        @(negedge clk);
        if (wr_ready) break;
        n++;
        if (n > 500) begin chk("wr_accept_timeout", 0, 1); break; end
      end
      step();
    end
    wr_valid = 1'b0;
    wr_data  = '0;
    @(negedge clk);
    chk("pulse_latency", is_mat ? mvm_loadMatrix : mvm_loadVector, 1);
    if (abort_at >= 0) begin
      repeat (abort_at + 1) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_mid_cmd_rdy", cmd_ready, 1);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_din", mvm_data_in, 0);
      chk("rst_mid_wr_rdy", wr_ready, 0);
      chk("rst_mid_loadm", mvm_loadMatrix, 0);
      chk("rst_mid_res_vld", res_valid, 0);
    end else begin
      repeat (t) @(negedge clk);
      chk("cmd_rdy_last_burst", cmd_ready, 0);
      @(negedge clk);
      chk("cmd_rdy_after_load", cmd_ready, 1);
    end
  endtask

  task automatic start_run(input int delay);
    int y[N];
    longint s;
    for (int r = 0; r < N; r++) begin
      s = 0;
      for (int c = 0; c < N; c++) s += longint'(ref_mat[r*N+c]) * ref_vec[c];
      exp_res.push_back(int'(s));
    end
    starts_exp++;
    send_cmd(2'd2);
    @(negedge clk);
    chk("start_latency", mvm_start, 1);
    // The stand-in core multiplies whatever it actually received.
    for (int r = 0; r < N; r++) begin
      s = 0;
      for (int c = 0; c < N; c++) s += longint'(core_mat[r*N+c]) * core_vec[c];
      y[r] = int'(s);
    end
    step();
    repeat (delay) step();
    mvm_done = 1'b1;
    for (int j = 0; j < N; j++) begin
      step();
      mvm_done     = 1'b0;
      mvm_data_out = OW'(y[j]);
    end
    @(negedge clk);
    chk("res_vld_early", res_valid, 0);
    step();
    mvm_data_out = 32'hdead_beef;
    @(negedge clk);
    chk("res_vld_latency", res_valid, 1);
    step();
    mvm_data_out = '0;
  endtask

  task automatic drain(input bit bp);
    int got = 0;
    int cyc = 0;
    seen_res.delete();
    if (bp) begin
      res_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        chk("stall_res_vld", res_valid, 1);
        chk("stall_cmd_rdy", cmd_ready, 0);
        step();
      end
    end
    while (got < N && cyc < 200) begin
      res_ready = !bp || (cyc % 2 == 0);
      @(negedge clk);
      if (res_valid && res_ready) got++;
      step();
      cyc++;
    end
    res_ready = 1'b0;
    chk("drain_count", got, N);
    chk("drain_all_expected", exp_res.size(), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_last", res_last, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_op_err", op_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_loadm", mvm_loadMatrix, 0);
    chk("rst_loadv", mvm_loadVector, 0);
    chk("rst_start", mvm_start, 0);
    chk("rst_din", mvm_data_in, 0);

    // Identity matrix, x = 1..8, gapless source.
    for (int i = 0; i < N*N; i++) ref_mat[i] = (i / N == i % N) ? 1 : 0;
    for (int i = 0; i < N; i++) ref_vec[i] = i + 1;
    load(1'b1, 1'b0, -1);
    load(1'b0, 1'b0, -1);
    chk("ident_core_diag", core_mat[9], 1);
    chk("ident_core_off", core_mat[10], 0);
    start_run(3);
    drain(1'b0);
    for (int i = 0; i < N; i++) chk("ident_y", seen_res.size() > i ? seen_res[i] : -1, i + 1);

    // Illegal op: single pulse, then three back-to-back.
    send_cmd(2'd3);
    @(negedge clk);
    chk("illegal_err_pulse", op_err, 1);
    chk("illegal_cmd_rdy", cmd_ready, 1);
    chk("illegal_busy", busy, 0);
    step();
    @(negedge clk);
    chk("illegal_err_single", op_err, 0);
    step();
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n += int'(op_err);
      step();
      if (i == 2) cmd_valid = 1'b0;
    end
    chk("illegal_b2b_count", n, 3);

    // Spurious done while idle.
    step();
    mvm_done = 1'b1;
    step();
    mvm_done = 1'b0;
    @(negedge clk);
    chk("spur_done_busy", busy, 0);
    chk("spur_done_rdy", cmd_ready, 1);
    repeat (5) step();

    // Signed operands, gappy source, result backpressure.
    for (int i = 0; i < N*N; i++) ref_mat[i] = int'($urandom_range(0, 23170)) - 11585;
    for (int i = 0; i < N; i++) ref_vec[i] = int'($urandom_range(0, 23170)) - 11585;
    load(1'b1, 1'b1, -1);
    load(1'b0, 1'b1, -1);
    start_run(5);
    drain(1'b1);

    // Reset while matrix word 30 is on the core bus, then a full reload and a late done.
    for (int i = 0; i < N*N; i++) ref_mat[i] = 100 + i;
    load(1'b1, 1'b0, 30);
    repeat (3) step();
    for (int i = 0; i < N*N; i++) ref_mat[i] = i / N + 1;
    for (int i = 0; i < N; i++) ref_vec[i] = 1;
    load(1'b1, 1'b0, -1);
    load(1'b0, 1'b0, -1);
    start_run(100);
    drain(1'b0);
    for (int r = 0; r < N; r++) chk("reload_y", seen_res.size() > r ? seen_res[r] : -1, 8 * (r + 1));

    repeat (4) step();
    chk("burst_queue_empty", exp_burst.size(), 0);
    chk("pulse_queue_empty", exp_kind.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mvm_host_ctrl.md
# mvm_host_ctrl

Host-side initiator for the `mvm` matrix-vector multiply core. It accepts load and start commands from an upstream stream interface and buffers operand words, because the core cannot tolerate gaps. It then replays the words to the core with the exact loadMatrix/loadVector/start pulse protocol, captures the core's gapless result burst after `done`, and returns the results on a backpressured output stream. It sits between the system bus adapter and one `mvm` instance.

## Interface
- `MAT_SCALE`, 8: matrix dimension N; the matrix is N×N and the vectors have N elements.
- `INPUT_WIDTH`, 16: operand word width, signed.
- `OUTPUT_WIDTH`, 2*INPUT_WIDTH: result word width, signed.
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high. It is shared with the attached `mvm` core.
- `cmd_valid` in 1, `cmd_ready` out 1, `cmd_op` in 2: command stream. 0 = load matrix, 1 = load vector, 2 = start, 3 = illegal.
- `wr_valid` in 1, `wr_ready` out 1, `wr_data` in INPUT_WIDTH: operand word stream. Words arrive row-major for the matrix.
- `res_valid` out 1, `res_ready` in 1, `res_data` out OUTPUT_WIDTH, `res_last` out 1: result stream.
- `op_err` out 1: one-cycle pulse when an illegal op is accepted.
- `busy` out 1: high in every state except IDLE.
- `mvm_loadMatrix`, `mvm_loadVector`, `mvm_start` out 1: core control pulses.
- `mvm_data_in` out INPUT_WIDTH: core operand input.
- `mvm_done` in 1, `mvm_data_out` in OUTPUT_WIDTH: core status and result.

## Operation
- Internal state:
  - operand buffer of N*N words;
  - result buffer of N words;
  - word counter of width clog2(N*N+1);
  - latched op.
- **IDLE**
  - `cmd_ready`=1. All other handshake outputs and core controls are 0.
  - A handshake with op 0 or 1 latches the op, clears the counter and goes to FILL.
  - Op 2 goes to START.
  - Op 3 pulses `op_err` for the next cycle and stays in IDLE.
- **FILL**
  - `wr_ready`=1. Each `wr_valid && wr_ready` stores `wr_data` at buf[count] and increments count.
  - The target is N*N words for op 0 and N for op 1.
  - When the last word is accepted, go to PULSE.
  - `wr_valid` gaps are allowed and simply stall.
- **PULSE**
  - One cycle. `mvm_loadMatrix` (op 0) or `mvm_loadVector` (op 1) = 1.
  - Counter clears. Go to BURST.
- **BURST**
  - Exactly target cycles with no gaps. `mvm_data_in` = buf[count], and count increments each cycle.
  - After the last word, go to IDLE.
- **START**
  - One cycle with `mvm_start`=1. Go to WAIT.
- **WAIT**
  - Hold until `mvm_done`=1 is sampled, then go to CAPTURE with the counter cleared.
  - There is no timeout.
- **CAPTURE**
  - N cycles. Result y[0] is on `mvm_data_out` in the cycle after the `mvm_done`=1 cycle; y[j] follows j cycles later.
  - Store each y[j] into res[j]. After the Nth capture, go to DRAIN with the counter cleared.
- **DRAIN**
  - `res_valid`=1, `res_data`=res[count], `res_last`=(count==N-1).
  - The counter advances on each `res_valid && res_ready`.
  - After the last handshake, go to IDLE.
- Results are passed through bit-exact. The block does no arithmetic or sign handling beyond storage.
- Buffer contents persist across commands. Data loaded into the core is the core's responsibility.
- `mvm_done` outside WAIT is ignored. `wr_valid` outside FILL is ignored (`wr_ready`=0).
- A start issued before any load is forwarded unchanged; the result is whatever the core produces.

## Timing
- Reset values:
  - state = IDLE, counter = 0;
  - `cmd_ready`=1 in the first cycle after reset;
  - every other output = 0, including `mvm_data_in` and `res_data`.
- Reset mid-operation, in any state, aborts the command. Buffered words and undrained results are discarded, and no further core pulses are issued.
- Core drive rules:
  - `mvm_data_in` is registered and is 0 outside BURST.
  - Word k of a load appears exactly k+1 cycles after the load pulse cycle.
- Load latency, measured from acceptance of the last `wr` word:
  - 1 cycle to PULSE;
  - then N*N (matrix) or N (vector) BURST cycles;
  - `cmd_ready` reasserts in the following cycle.
- Start latency:
  - `mvm_start` is asserted in the cycle after command acceptance;
  - the first `res_valid` is asserted N+1 cycles after the `mvm_done` cycle.
- `res_ready` low stalls DRAIN indefinitely. No new command is accepted meanwhile.
- `op_err` is exactly one cycle per illegal op; back-to-back illegal ops give back-to-back pulses.

## Test plan
- **Identity matrix.** Load the 8×8 identity and x=1..8 with `wr_valid` held high, then start → the core sees `loadMatrix`, then 64 gapless words; `res_data`=1..8 with `res_last` on the 8th.
- **Signed operands with a gappy source.** Random signed 16-bit operands with magnitude below 32767/8^0.5, `wr_valid` toggled 50% → bursts to the core are still gapless. Results match a reference model in 32-bit signed arithmetic.
- **Backpressure on results.** `res_ready` low for 20 cycles, then high every other cycle → 8 results in order, none lost or duplicated, `res_last` only on y[7].
- **Illegal op.** `cmd_op`=3 → `op_err` high for 1 cycle; no core pulse; `cmd_ready` stays 1.
- **Reset during operation.** Reset asserted mid-BURST (word 30 of 64) → the next cycle is IDLE, all outputs are 0, and no further `mvm_data_in` values are driven. A following full load plus start gives the correct result.
- **Spurious done and late done.** `mvm_done` pulsed during IDLE → ignored. `mvm_done` delayed 100 cycles after start → capture begins the cycle after done, and y[0] is correct.
